// File: rtl/fpalu_pkg.sv
// Shared constants and types for the FP32 add-path normalise/round stage.
// Significand layout is {carry, hidden, frac[22:0], G, R, S}.
package fpalu_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned SIG_W = MAN_W + 5;
    localparam int unsigned E_W   = EXP_W + 2;
    localparam int unsigned LZ_W  = 5;

    localparam int unsigned       FP32_BIAS = 127;
    localparam logic [31:0]       FP32_QNAN = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0]  EXP_MAX   = 8'hFF;

    localparam int unsigned SIG_CARRY    = SIG_W - 1;
    localparam int unsigned SIG_HIDDEN   = SIG_W - 2;
    localparam int unsigned SIG_FRAC_MSB = SIG_W - 3;
    localparam int unsigned SIG_FRAC_LSB = 3;
    localparam int unsigned SIG_G        = 2;
    localparam int unsigned SIG_R        = 1;
    localparam int unsigned SIG_S        = 0;

    typedef enum logic [2:0] {
        TAG_NORMAL,
        TAG_ZERO,
        TAG_UFLOW,
        TAG_INF,
        TAG_NAN
    } tag_t;

    typedef struct packed {
        logic                   sign;
        tag_t                   tag;
        logic signed [E_W-1:0]  e;
        logic [MAN_W-1:0]       frac;
        logic                   g;
        logic                   r;
        logic                   s;
    } s1_t;

endpackage

// File: rtl/fpalu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpalu_lzc
    import fpalu_pkg::*;
#(
    parameter int unsigned WIDTH = SIG_W - 1,
    parameter int unsigned CNT_W = LZ_W
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] count
);

    logic found;

    always_comb begin
        count = CNT_W'(WIDTH);
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && vec[WIDTH-1-i]) begin
                count = CNT_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpalu_norm_round.sv
// FP32 add path post-sum stage: S1 normalises, S2 rounds (RNE) and packs with flags.
// Two-entry valid/ready pipeline, one result per cycle.
module fpalu_norm_round
    import fpalu_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [SIG_W-1:0]       in_sig,
    input  logic                   in_inf,
    input  logic                   in_nan,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   sum,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact
);

    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;
    s1_t  s1_d;
    s1_t  s1_q;

    logic [LZ_W-1:0]          lz;
    logic [SIG_W-3:0]         sig_shl;
    logic signed [E_W-1:0]    exp_ext;
    logic signed [E_W-1:0]    e_shl;

    logic                     round_up;
    logic [MAN_W:0]           frac_rnd;
    logic signed [E_W-1:0]    e_rnd;
    logic [EXP_W+MAN_W:0]     res_sum;
    logic                     res_ov;
    logic                     res_uf;
    logic                     res_ix;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    fpalu_lzc #(
        .WIDTH (SIG_W - 1),
        .CNT_W (LZ_W)
    ) u_lzc (
        .vec   (in_sig[SIG_HIDDEN:0]),
        .count (lz)
    );

    // Truncating to the fraction/GRS width drops the hidden bit after the shift.
    assign sig_shl = in_sig[SIG_FRAC_MSB:0] << lz;
    assign exp_ext = $signed(E_W'(in_exp));
    assign e_shl   = exp_ext - $signed(E_W'(lz));

    always_comb begin
        s1_d      = '0;
        s1_d.tag  = TAG_NORMAL;
        s1_d.sign = in_sign;
        if (in_nan) begin
            s1_d.tag = TAG_NAN;
        end else if (in_inf) begin
            s1_d.tag = TAG_INF;
        end else if (in_sig == '0) begin
            s1_d.tag = TAG_ZERO;
        end else if (in_sig[SIG_CARRY]) begin
            s1_d.e    = exp_ext + E_W'(1);
            s1_d.frac = in_sig[SIG_HIDDEN:SIG_FRAC_LSB+1];
            s1_d.g    = in_sig[SIG_FRAC_LSB];
            s1_d.r    = in_sig[SIG_G];
            s1_d.s    = in_sig[SIG_R] | in_sig[SIG_S];
        end else begin
            s1_d.tag  = (e_shl <= 0) ? TAG_UFLOW : TAG_NORMAL;
            s1_d.e    = e_shl;
            s1_d.frac = sig_shl[SIG_FRAC_MSB:SIG_FRAC_LSB];
            s1_d.g    = sig_shl[SIG_G];
            s1_d.r    = sig_shl[SIG_R];
            s1_d.s    = sig_shl[SIG_S];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Carry out of {1,frac}+up is the same as carry out of {0,frac}+up.
    assign round_up = s1_q.g & (s1_q.r | s1_q.s | s1_q.frac[0]);
    assign frac_rnd = {1'b0, s1_q.frac} + (MAN_W+1)'(round_up);
    assign e_rnd    = frac_rnd[MAN_W] ? s1_q.e + E_W'(1) : s1_q.e;

    always_comb begin
        res_sum = '0;
        res_ov  = 1'b0;
        res_uf  = 1'b0;
        res_ix  = 1'b0;
        case (s1_q.tag)
            TAG_NAN: begin
                res_sum = FP32_QNAN;
            end
            TAG_INF: begin
                res_sum = {s1_q.sign, EXP_MAX, {MAN_W{1'b0}}};
            end
            TAG_ZERO: begin
                res_sum = '0;
            end
            TAG_UFLOW: begin
                res_uf = 1'b1;
                res_ix = 1'b1;
            end
            default: begin
                if (e_rnd >= $signed({2'b00, EXP_MAX})) begin
                    res_sum = {s1_q.sign, EXP_MAX, {MAN_W{1'b0}}};
                    res_ov  = 1'b1;
                    res_ix  = 1'b1;
                end else begin
                    res_sum = {s1_q.sign, e_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
                    res_ix  = s1_q.g | s1_q.r | s1_q.s;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum       <= res_sum;
                overflow  <= res_ov;
                underflow <= res_uf;
                inexact   <= res_ix;
            end
        end
    end

endmodule

// File: tb/tb_fpalu_norm_round.sv
// Scoreboard bench for fpalu_norm_round: directed corner vectors plus random traffic
// with random backpressure, checked against an independent arithmetic model.
module tb_fpalu_norm_round;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sign = 1'b0;
    logic [7:0]   in_exp = '0;
    logic [27:0]  in_sig = '0;
    logic         in_inf = 1'b0;
    logic         in_nan = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  sum;
    logic         overflow;
    logic         underflow;
    logic         inexact;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        ov;
        logic        uf;
        logic        ix;
    } exp_t;

    exp_t sb[$];

    typedef struct packed {
        logic        sign;
        logic [7:0]  ex;
        logic [27:0] sig;
        logic        inf;
        logic        nan;
        logic [31:0] sum;
        logic        ov;
        logic        uf;
        logic        ix;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    fpalu_norm_round dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .in_inf    (in_inf),
        .in_nan    (in_nan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: normalise by repeated shifting, round on the 3 low bits as a remainder.
    function automatic logic [34:0] model(input logic sgn, input logic [7:0] ex,
                                          input logic [27:0] sg, input logic inf, input logic nan);
        int e;
        int unsigned m, keep, rem;
        if (nan) return {32'h7FC0_0000, 3'b000};
        if (inf) return {sgn, 8'hFF, 23'h0, 3'b000};
        if (sg == 28'h0) return 35'h0;
        e = int'(ex);
        m = 32'(sg);
        if (m >= 32'h800_0000) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end else begin
            while (m < 32'h400_0000) begin
                m = m << 1;
                e = e - 1;
            end
        end
        if (e <= 0) return {32'h0, 3'b011};
        keep = m >> 3;
        rem  = m & 7;
        if (rem > 4 || (rem == 4 && (keep & 1) == 1)) keep = keep + 1;
        if (keep == 32'h100_0000) begin
            keep = keep >> 1;
            e = e + 1;
        end
        if (e >= 255) return {sgn, 8'hFF, 23'h0, 3'b101};
        return {sgn, 8'(e), keep[22:0], 2'b00, rem != 0};
    endfunction

    task automatic load_vecs();
        vecs[0]  = {1'b0, 8'h7F, 28'hC000000, 2'b00, 32'h4040_0000, 3'b000};
        vecs[1]  = {1'b0, 8'h7F, 28'h1000000, 2'b00, 32'h3E80_0000, 3'b000};
        vecs[2]  = {1'b0, 8'h7F, 28'h400000C, 2'b00, 32'h3F80_0002, 3'b001};
        vecs[3]  = {1'b0, 8'h7F, 28'h4000004, 2'b00, 32'h3F80_0000, 3'b001};
        vecs[4]  = {1'b0, 8'hFE, 28'h8000000, 2'b00, 32'h7F80_0000, 3'b101};
        vecs[5]  = {1'b0, 8'h01, 28'h2000000, 2'b00, 32'h0000_0000, 3'b011};
        vecs[6]  = {1'b0, 8'h01, 28'h0000000, 2'b00, 32'h0000_0000, 3'b000};
        vecs[7]  = {1'b1, 8'h00, 28'h0000000, 2'b11, 32'h7FC0_0000, 3'b000};
        vecs[8]  = {1'b1, 8'h00, 28'h0000000, 2'b10, 32'hFF80_0000, 3'b000};
        vecs[9]  = {1'b0, 8'h7F, 28'h7FFFFFD, 2'b00, 32'h4000_0000, 3'b001};
        vecs[10] = {1'b1, 8'h80, 28'h4000000, 2'b00, 32'hC000_0000, 3'b000};
        vecs[11] = {1'b0, 8'h7F, 28'hC000001, 2'b00, 32'h4040_0000, 3'b001};
        vecs[12] = {1'b0, 8'h7F, 28'hC000018, 2'b00, 32'h4040_0002, 3'b001};
        vecs[13] = {1'b0, 8'h02, 28'h2000000, 2'b00, 32'h0080_0000, 3'b000};
        vecs[14] = {1'b0, 8'hFF, 28'h4000000, 2'b00, 32'h7F80_0000, 3'b101};
        vecs[15] = {1'b1, 8'h55, 28'h0000000, 2'b00, 32'h0000_0000, 3'b000};
    endtask

    task automatic drive_vec(input int i);
        in_sign = vecs[i].sign;
        in_exp  = vecs[i].ex;
        in_sig  = vecs[i].sig;
        in_inf  = vecs[i].inf;
        in_nan  = vecs[i].nan;
    endtask

    task automatic push_vec(input int i);
        exp_t e;
        e.id  = i;
        e.sum = vecs[i].sum;
        e.ov  = vecs[i].ov;
        e.uf  = vecs[i].uf;
        e.ix  = vecs[i].ix;
        sb.push_back(e);
    endtask

    task automatic rand_stim();
        int kind;
        kind    = $urandom_range(0, 19);
        in_sign = 1'($urandom);
        in_nan  = (kind == 0);
        in_inf  = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
        if (kind == 2)      in_exp = 8'($urandom_range(1, 3));
        else if (kind == 3) in_exp = 8'($urandom_range(253, 255));
        else                in_exp = 8'($urandom_range(1, 254));
        if (kind == 4)                   in_sig = 28'h0;
        else if (kind >= 5 && kind <= 9) in_sig = {1'b1, 27'($urandom)};
        else if (kind >= 10 && kind <= 14) in_sig = {2'b01, 26'($urandom)};
        else in_sig = {1'b0, 27'($urandom)} >> $urandom_range(0, 26);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        if (out_valid !== 1'b0) errors++;
        checks++;
        if ({sum, overflow, underflow, inexact} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got sum=%h flags=%b%b%b want 0", sum, overflow, underflow, inexact);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive_vec(0);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid got %b want 0 one cycle after accept", out_valid);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h4040_0000) begin
            errors++;
            $display("FAIL latency_2cyc: got valid=%b sum=%h want valid=1 sum=40400000", out_valid, sum);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        exp_t e;
        out_ready = 1'b1;
        while (got < NVEC && cyc < 200) begin
            if (sent < NVEC) begin
                drive_vec(sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL directed_extra: unexpected output sum=%h", sum);
                end else begin
                    e = sb.pop_front();
                    if ({sum, overflow, underflow, inexact} !== {e.sum, e.ov, e.uf, e.ix}) begin
                        errors++;
                        $display("FAIL directed[%0d]: got sum=%h ov=%b uf=%b ix=%b want sum=%h ov=%b uf=%b ix=%b",
                                 e.id, sum, overflow, underflow, inexact, e.sum, e.ov, e.uf, e.ix);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                push_vec(sent);
                sent++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got < NVEC) begin
            errors++;
            $display("FAIL directed_timeout: got %0d results want %0d", got, NVEC);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        int cyc = 0;
        exp_t e;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_vec(acc);
            in_valid = 1'b1;
            @(negedge clock);
            checks++;
            if (in_ready !== (c < 2)) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, (c < 2));
            end
            if (in_valid && in_ready) begin
                push_vec(acc);
                acc++;
            end
            @(posedge clock); #1;
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d want 2", acc);
        end
        out_ready = 1'b1;
        while (got < 3 && cyc < 20) begin
            if (acc < 3) begin
                drive_vec(acc);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (out_valid) begin
                checks++;
                e = sb.pop_front();
                if ({sum, overflow, underflow, inexact} !== {e.sum, e.ov, e.uf, e.ix}) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got sum=%h flags=%b%b%b want sum=%h flags=%b%b%b",
                             e.id, sum, overflow, underflow, inexact, e.sum, e.ov, e.uf, e.ix);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                push_vec(acc);
                acc++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got < 3) begin
            errors++;
            $display("FAIL bp_drain_timeout: got %0d results want 3", got);
        end
    endtask

    task automatic test_back_to_back(input int n);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic taken = 1'b0;
        logic held = 1'b0;
        logic [35:0] held_val = '0;
        logic [34:0] m;
        exp_t e;
        in_valid = 1'b0;
        while ((sent < n || got < sent) && cyc < 20000) begin
            if (!in_valid || taken) begin
                if (sent < n && $urandom_range(0, 9) < 8) begin
                    rand_stim();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            taken = 1'b0;
            @(negedge clock);
            if (held) begin
                checks++;
                if ({out_valid, sum, overflow, underflow, inexact} !== held_val) begin
                    errors++;
                    $display("FAIL stall_hold: got %h want %h", {out_valid, sum, overflow, underflow, inexact}, held_val);
                end
            end
            held = out_valid && !out_ready;
            held_val = {out_valid, sum, overflow, underflow, inexact};
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra: unexpected output sum=%h", sum);
                end else begin
                    e = sb.pop_front();
                    if ({sum, overflow, underflow, inexact} !== {e.sum, e.ov, e.uf, e.ix}) begin
                        errors++;
                        $display("FAIL random[%0d]: got sum=%h flags=%b%b%b want sum=%h flags=%b%b%b",
                                 e.id, sum, overflow, underflow, inexact, e.sum, e.ov, e.uf, e.ix);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                m = model(in_sign, in_exp, in_sig, in_inf, in_nan);
                e.id  = sent;
                e.sum = m[34:3];
                e.ov  = m[2];
                e.uf  = m[1];
                e.ix  = m[0];
                sb.push_back(e);
                sent++;
                taken = 1'b1;
            end
            @(posedge clock); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL random_timeout: got %0d results want %0d", got, n);
        end
    endtask

    task automatic test_midflight_reset();
        logic stale = 1'b0;
        int cyc = 0;
        logic seen = 1'b0;
        out_ready = 1'b0;
        drive_vec(4);
        in_valid = 1'b1;
        @(posedge clock); #1;
        drive_vec(5);
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_preload: out_valid got %b want 1", out_valid);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || {sum, overflow, underflow, inexact} !== 35'h0) begin
            errors++;
            $display("FAIL rst_midflight: got valid=%b sum=%h want valid=0 sum=0", out_valid, sum);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (out_valid) stale = 1'b1;
            @(posedge clock); #1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL rst_stale: got stale output after reset want none");
        end
        drive_vec(2);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clock);
            if (out_valid) begin
                seen = 1'b1;
                checks++;
                if ({sum, overflow, underflow, inexact} !== {vecs[2].sum, vecs[2].ov, vecs[2].uf, vecs[2].ix}) begin
                    errors++;
                    $display("FAIL rst_first_result: got sum=%h ix=%b want sum=%h ix=%b",
                             sum, inexact, vecs[2].sum, vecs[2].ix);
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_recover_timeout: got no output want one");
        end
    endtask

    initial begin
        load_vecs();
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_back_to_back(400);
        test_midflight_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
